// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package i2c_target_pkg;

  localparam int BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA and derives edge and START/STOP pulses.
// Latency: pulses are valid 2 clk after the pin change (2-FF sync), compared to a history stage.
// Backpressure: none; pin levels are sampled every clk.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_m_q, scl_m_d, scl_s_q, scl_s_d, scl_h_q, scl_h_d;
  logic sda_m_q, sda_m_d, sda_s_q, sda_s_d, sda_h_q, sda_h_d;

  // Shift chain: metastability stage, stable stage, one-cycle history.
  always_comb begin
    scl_m_d = scl_i;
    scl_s_d = scl_m_q;
    scl_h_d = scl_s_q;
    sda_m_d = sda_i;
    sda_s_d = sda_m_q;
    sda_h_d = sda_s_q;
  end

  // Idle bus level is high, so every stage resets to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_h_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= scl_m_d;
      scl_s_q <= scl_s_d;
      scl_h_q <= scl_h_d;
      sda_m_q <= sda_m_d;
      sda_s_q <= sda_s_d;
      sda_h_q <= sda_h_d;
    end
  end

  assign sda_s     = sda_s_q;
  assign scl_rise  = scl_s_q & ~scl_h_q;
  assign scl_fall  = ~scl_s_q & scl_h_q;
  assign start_det = scl_s_q & sda_h_q & ~sda_s_q;
  assign stop_det  = scl_s_q & ~sda_h_q & sda_s_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an NREGS x 8 register file: pointer+data writes, auto-incrementing reads.
// Latency: sda_oe updates 3 clk after a raw SCL falling edge; wr_strobe 3 clk after the 8th SCL rise.
// Backpressure: never stretches SCL; the master paces everything, the host port is read-only.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREGS    = 16,
  localparam int        PW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_strobe,
  output logic [PW-1:0]     wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  input  logic [PW-1:0]     host_raddr,
  output logic [BYTE_W-1:0] host_rdata
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t    state_q, state_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [PW-1:0]     wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic [BYTE_W-1:0] regs_q [NREGS];
  logic [BYTE_W-1:0] regs_d [NREGS];

  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] rd_byte;
  logic [PW-1:0]     ptr_inc;

  // Protocol engine. bitcnt==8 in a receive state means "byte done, ACK on next SCL fall";
  // in RACK, 8 means "awaiting master ACK bit" and 0 means "next byte loaded, drive on fall".
  always_comb begin
    rx_byte     = {shift_q[BYTE_W-2:0], sda_s};
    rd_byte     = regs_q[ptr_q];
    ptr_inc     = ptr_q + PW'(1);
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && bitcnt_q != 4'd8) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = rx_byte[0];
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d = rx_byte[PW-1:0];
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_strobe_d   = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_inc;
              end
            end
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            if (state_q == ST_ADDR)     state_d = ST_ADDR_ACK;
            else if (state_q == ST_PTR) state_d = ST_PTR_ACK;
            else                        state_d = ST_WDATA_ACK;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = ST_PTR;
              bitcnt_d = 4'd0;
            end else begin
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = ST_RDATA;
              bitcnt_d = 4'd1;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WDATA;
            bitcnt_d = 4'd0;
          end
        end

        ST_RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RACK;
            end else begin
              shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
              sda_oe_d = ~shift_q[BYTE_W-2];
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end

        ST_RACK: begin
          if (scl_rise && bitcnt_q == 4'd8) begin
            if (sda_s == I2C_ACK) begin
              ptr_d    = ptr_inc;
              shift_d  = regs_q[ptr_inc];
              bitcnt_d = 4'd0;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall && bitcnt_q == 4'd0) begin
            sda_oe_d = ~shift_q[BYTE_W-1];
            state_d  = ST_RDATA;
            bitcnt_d = 4'd1;
          end
        end

        ST_WAIT_STOP: sda_oe_d = 1'b0;

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State, outputs and register file; everything clears on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_raddr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register model and write scoreboard.
// Latency: master quarter-bit is Q clk, far above the 3 clk target response.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr, host_raddr;
  logic [7:0] wr_data, host_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  model_regs [16];
  logic [3:0]  model_ptr;
  logic [11:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic        mon_quiet = 1'b0;
  int          oe_viol = 0;
  int          busy_viol = 0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard: every wr_strobe must match the oldest expected (addr,data).
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 32'(wr_addr), 32'hFFFF);
      end else begin
        logic [11:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[11:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
    if (mon_quiet) begin
      if (sda_oe) oe_viol++;
      if (busy) busy_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack);
  endtask

  task automatic send_addr(input logic [7:0] a, input logic exp_ack, input string tag);
    logic ack;
    write_byte(a, ack);
    chk(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic send_ptr(input logic [7:0] p);
    logic ack;
    write_byte(p, ack);
    chk("ptr_ack", 32'(ack), 32'(I2C_ACK));
    model_ptr = p[3:0];
  endtask

  task automatic send_data(input logic [7:0] d);
    logic ack;
    wr_q.push_back({model_ptr, d});
    model_regs[model_ptr] = d;
    model_ptr = model_ptr + 4'd1;
    write_byte(d, ack);
    chk("wdata_ack", 32'(ack), 32'(I2C_ACK));
  endtask

  task automatic recv_data(input logic mack);
    logic [7:0] got, e;
    rd_q.push_back(model_regs[model_ptr]);
    read_byte(got, mack);
    e = rd_q.pop_front();
    chk("rdata", 32'(got), 32'(e));
    if (mack == I2C_ACK) model_ptr = model_ptr + 4'd1;
  endtask

  task automatic host_chk(input logic [3:0] idx, input string tag);
    host_raddr = idx;
    #1;
    chk(tag, 32'(host_rdata), 32'(model_regs[idx]));
  endtask

  initial begin
    logic b;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_raddr = '0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 4'd0;
    repeat (5) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_strobe", 32'(wr_strobe), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    host_chk(4'd0, "rst_reg0");
    host_chk(4'd15, "rst_reg15");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic write: pointer 3, two data bytes.
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t1_addr_ack");
    chk("t1_busy", 32'(busy), 1);
    send_ptr(8'h03);
    send_data(8'h5A);
    send_data(8'hC3);
    i2c_stop();
    chk("t1_busy_stop", 32'(busy), 0);
    host_chk(4'd4, "t1_reg4");
    host_chk(4'd3, "t1_reg3");

    // Upper pointer bits ignored: 0xF1 selects register 1.
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t2a_addr_ack");
    send_ptr(8'hF1);
    send_data(8'h77);
    i2c_stop();
    host_chk(4'd1, "t2a_reg1");

    // Pointer wrap 15 -> 0, pointer ends at 1 and is retained into a read.
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t2_addr_ack");
    send_ptr(8'h0F);
    send_data(8'h11);
    send_data(8'h22);
    i2c_stop();
    host_chk(4'd15, "t2_reg15");
    host_chk(4'd0, "t2_reg0");
    chk("t2_ptr", 32'(dut.ptr_q), 32'(model_ptr));
    i2c_start();
    send_addr(8'hA1, I2C_ACK, "t2_raddr_ack");
    recv_data(I2C_NACK);
    i2c_stop();

    // Pointer write, repeated START, read with ACK then NACK.
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t3_addr_ack");
    send_ptr(8'h03);
    i2c_start();
    send_addr(8'hA1, I2C_ACK, "t3_raddr_ack");
    recv_data(I2C_ACK);
    recv_data(I2C_NACK);
    chk("t3_oe_after_nack", 32'(sda_oe), 0);
    chk("t3_busy_before_stop", 32'(busy), 1);
    i2c_stop();
    chk("t3_busy_after_stop", 32'(busy), 0);

    // Wrong address: never drives SDA, never busy, nothing written.
    mon_quiet = 1'b1;
    i2c_start();
    send_addr(8'hA2, I2C_NACK, "t4_addr_nack");
    send_addr(8'h03, I2C_NACK, "t4_b1_nack");
    send_addr(8'h99, I2C_NACK, "t4_b2_nack");
    i2c_stop();
    mon_quiet = 1'b0;
    chk("t4_oe_viol", 32'(oe_viol), 0);
    chk("t4_busy_viol", 32'(busy_viol), 0);
    host_chk(4'd3, "t4_reg3");

    // STOP mid data byte: no write, back to IDLE; then a clean write.
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t5_addr_ack");
    send_ptr(8'h05);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    chk("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t5_sda_oe", 32'(sda_oe), 0);
    chk("t5_busy", 32'(busy), 0);
    host_chk(4'd5, "t5_reg5_untouched");
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t5b_addr_ack");
    send_ptr(8'h05);
    send_data(8'h3C);
    i2c_stop();
    host_chk(4'd5, "t5b_reg5");

    // Reset while the target is pulling SDA low during a read.
    i2c_start();
    send_addr(8'hA0, I2C_ACK, "t6_addr_ack");
    send_ptr(8'h03);
    i2c_start();
    send_addr(8'hA1, I2C_ACK, "t6_raddr_ack");
    read_bit(b);
    chk("t6_bit7", 32'(b), 32'(model_regs[3][7]));
    read_bit(b);
    chk("t6_bit6", 32'(b), 32'(model_regs[3][6]));
    chk("t6_oe_pre_rst", 32'(sda_oe), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 4'd0;
    chk("t6_oe_rst", 32'(sda_oe), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_ptr_rst", 32'(dut.ptr_q), 0);
    host_chk(4'd3, "t6_reg3_rst");
    host_chk(4'd5, "t6_reg5_rst");
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("wr_pending", 32'(wr_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
